line_clear_ctrl: RTL and testbench
==================================

Name: line_clear_ctrl

Overview:
Sequences the board RAM (rows 3..22, 10 cells per row) to remove every full row and collapse the rows above it downward in one pass.
- Runs after a token locks, when the game FSM pulses start.
- Requests the shared board-RAM port from the board arbiter and uses it only while granted.
- Reports the number of rows cleared to the scoring logic.

Parameters:
W, 10, row width in cells
AW, 5, row address width
ROW_TOP, 3, topmost playable row
ROW_BOT, 22, bottom playable row (scan starts here)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
start  in  1  one-cycle request to begin a clear pass; accepted only in IDLE
bus_req  out  1  RAM port request; high from leaving IDLE until DONE
bus_gnt  in  1  RAM port grant from the board arbiter
rd_en  out  1  RAM read strobe
read_address  out  AW  RAM read row
rd_data  in  W  RAM read data, valid the cycle after rd_en (synchronous read)
we  out  1  RAM write strobe
write_address  out  AW  RAM write row
bus_data_o  out  W  RAM write data
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse at pass completion
lines_cleared  out  AW  full rows removed in the last pass; held until the next accepted start

Behaviour:
- Reset (reset=0, asynchronous) drives every output to 0 and the state to IDLE. src, dst, row_q and the count clear to 0.
- A reset during a pass abandons it. RAM contents are left as partially written; there is no recovery.
- Registers:
  - src, dst: AW bits, row pointers.
  - row_q: W bits, captured row.
  - cnt: AW bits, cleared-row count.
- All outputs are registered or decoded from registered state only. No output depends combinationally on rd_data.
- IDLE:
  - busy=0.
  - On start: src=dst=ROW_BOT, cnt=0, lines_cleared=0, go to REQ.
- REQ: bus_req=1. Go to RD when bus_gnt=1.
- RD:
  - If bus_gnt=1: rd_en=1, read_address=src, go to CAP.
  - Otherwise stall in RD with rd_en=0.
- CAP: row_q<=rd_data unconditionally; go to EVAL. The grant state is ignored here because the read was already issued.
- EVAL, full row (row_q all ones):
  - cnt<=cnt+1. No write.
  - If src==ROW_TOP go to FILL; else src<=src-1 and go to RD.
- EVAL, partial row, src!=dst:
  - Requires bus_gnt=1: we=1, write_address=dst, bus_data_o=row_q.
  - Then dst<=dst-1, and advance src exactly as for a full row.
  - If bus_gnt=0: stall in EVAL with we=0.
- EVAL, partial row, src==dst: no write; dst<=dst-1; advance src.
- FILL (zero the vacated top rows):
  - If dst==ROW_TOP-1 go to DONE.
  - Else if bus_gnt=1: we=1, write_address=dst, bus_data_o=0, dst<=dst-1.
  - Else stall.
- DONE: done=1 for one cycle, lines_cleared<=cnt, bus_req drops, go to IDLE.
- Invariants:
  - dst>=src-1 always.
  - dst never decrements below ROW_TOP-1; that is its terminal value.
  - Writes never target a row above src.
- Timing: 3 cycles per scanned row plus 1 cycle per FILL write, with no stalls.
  - With no full rows (no writes, no fill): 2 + 3*20 + 1 = 63 cycles from start to done.
- Start while busy is ignored. Start on the same cycle as the done pulse is ignored. Start on the cycle after done is accepted.
- we and rd_en are never asserted while bus_gnt=0, except rd_en-induced data capture in CAP, which does not touch the port.

Test Plan:
- No full rows, bus_gnt tied 1, rows 3..22 = 10'h155 -> zero we pulses, done 63 cycles after start, lines_cleared=0, RAM unchanged.
- Row 22 full, rows 3..21 distinct patterns (row N = N) -> after done, row 22=21, row 21=20, ..., row 4=3, row 3=0, lines_cleared=1.
- Rows 22, 20, 19 full; row 21=10'h0AA; others 10'h001 -> row 22=10'h0AA, rows 4..21 shifted down per algorithm, rows 3..5 = 0, lines_cleared=3.
- Same as the previous case, with bus_gnt held low for 5 cycles in each of REQ, RD, EVAL-write and FILL -> identical final RAM; rd_en/we never high with bus_gnt low; done delayed by exactly 20 cycles.
- All 20 rows full -> no shifted writes, FILL writes 0 to rows 22..3 (20 writes), lines_cleared=20.
- reset=0 asserted mid-FILL, then start issued again -> all outputs 0 immediately on reset; second pass completes normally; start pulses issued while busy produce no second done.

Source files
------------

// File: rtl/line_clear_ctrl.sv
// Line-clear sequencer: scans board rows bottom-up, drops full rows, compacts the rest downward
// and zero-fills the vacated top rows, using the shared board-RAM port only while granted.
module line_clear_ctrl #(
    parameter int unsigned W       = 10,
    parameter int unsigned AW      = 5,
    parameter int unsigned ROW_TOP = 3,
    parameter int unsigned ROW_BOT = 22
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    output logic          bus_req,
    input  logic          bus_gnt,
    output logic          rd_en,
    output logic [AW-1:0] read_address,
    input  logic [W-1:0]  rd_data,
    output logic          we,
    output logic [AW-1:0] write_address,
    output logic [W-1:0]  bus_data_o,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] lines_cleared
);

    localparam logic [AW-1:0] RowTop   = AW'(ROW_TOP);
    localparam logic [AW-1:0] RowBot   = AW'(ROW_BOT);
    localparam logic [AW-1:0] RowTopM1 = AW'(ROW_TOP - 1);

    typedef enum logic [2:0] {StIdle, StReq, StRd, StCap, StEval, StFill, StDone} state_e;

    state_e        state_q, state_d;
    logic [AW-1:0] src_q, src_d;
    logic [AW-1:0] dst_q, dst_d;
    logic [W-1:0]  row_q, row_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic [AW-1:0] lines_q, lines_d;
    logic          advance;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            src_q   <= '0;
            dst_q   <= '0;
            row_q   <= '0;
            cnt_q   <= '0;
            lines_q <= '0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            row_q   <= row_d;
            cnt_q   <= cnt_d;
            lines_q <= lines_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        src_d         = src_q;
        dst_d         = dst_q;
        row_d         = row_q;
        cnt_d         = cnt_q;
        lines_d       = lines_q;
        advance       = 1'b0;
        bus_req       = 1'b0;
        busy          = 1'b1;
        done          = 1'b0;
        rd_en         = 1'b0;
        read_address  = '0;
        we            = 1'b0;
        write_address = '0;
        bus_data_o    = '0;

        unique case (state_q)
            StIdle: begin
                busy = 1'b0;
                if (start) begin
                    src_d   = RowBot;
                    dst_d   = RowBot;
                    cnt_d   = '0;
                    lines_d = '0;
                    state_d = StReq;
                end
            end
            StReq: begin
                bus_req = 1'b1;
                if (bus_gnt) state_d = StRd;
            end
            StRd: begin
                bus_req = 1'b1;
                if (bus_gnt) begin
                    rd_en        = 1'b1;
                    read_address = src_q;
                    state_d      = StCap;
                end
            end
            StCap: begin
                // Read already issued; capture regardless of the current grant.
                bus_req = 1'b1;
                row_d   = rd_data;
                state_d = StEval;
            end
            StEval: begin
                bus_req = 1'b1;
                if (&row_q) begin
                    cnt_d   = cnt_q + AW'(1);
                    advance = 1'b1;
                end else if (src_q != dst_q) begin
                    if (bus_gnt) begin
                        we            = 1'b1;
                        write_address = dst_q;
                        bus_data_o    = row_q;
                        dst_d         = dst_q - AW'(1);
                        advance       = 1'b1;
                    end
                end else begin
                    // Row already in place: just move the destination along.
                    dst_d   = dst_q - AW'(1);
                    advance = 1'b1;
                end
                if (advance) begin
                    if (src_q == RowTop) begin
                        state_d = StFill;
                    end else begin
                        src_d   = src_q - AW'(1);
                        state_d = StRd;
                    end
                end
            end
            StFill: begin
                bus_req = 1'b1;
                if (dst_q == RowTopM1) begin
                    state_d = StDone;
                end else if (bus_gnt) begin
                    we            = 1'b1;
                    write_address = dst_q;
                    dst_d         = dst_q - AW'(1);
                end
            end
            StDone: begin
                done    = 1'b1;
                lines_d = cnt_q;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign lines_cleared = lines_q;

endmodule

// File: tb/tb_line_clear_ctrl.sv
// Bench for line_clear_ctrl: behavioural board RAM, table of directed passes with a compaction
// model, plus hand sequences for reset mid-FILL and start pulses around the done pulse.
module tb_line_clear_ctrl;

    localparam int W  = 10;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic          bus_req;
    logic          bus_gnt = 1'b1;
    logic          rd_en;
    logic [AW-1:0] read_address;
    logic [W-1:0]  rd_data;
    logic          we;
    logic [AW-1:0] write_address;
    logic [W-1:0]  bus_data_o;
    logic          busy;
    logic          done;
    logic [AW-1:0] lines_cleared;

    line_clear_ctrl #(.W(W), .AW(AW), .ROW_TOP(3), .ROW_BOT(22)) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .bus_req       (bus_req),
        .bus_gnt       (bus_gnt),
        .rd_en         (rd_en),
        .read_address  (read_address),
        .rd_data       (rd_data),
        .we            (we),
        .write_address (write_address),
        .bus_data_o    (bus_data_o),
        .busy          (busy),
        .done          (done),
        .lines_cleared (lines_cleared)
    );

    always #5 clk = ~clk;

    // Board RAM with a backdoor load port; synchronous read.
    logic [W-1:0]  mem [32];
    logic          bd_we = 1'b0;
    logic [4:0]    bd_addr = '0;
    logic [W-1:0]  bd_data = '0;

    always @(posedge clk) begin
        if (bd_we) mem[bd_addr] <= bd_data;
        else if (we) mem[write_address] <= bus_data_o;
        if (rd_en) rd_data <= mem[read_address];
    end

    int nerr = 0;
    int nchk = 0;
    logic [W-1:0] pre [32];
    logic [W-1:0] exp_mem [32];

    typedef struct {
        int         kind;
        bit         stalls;
        int         exp_lat;
        int         exp_lines;
        int         exp_writes;
        logic [9:0] exp_r22;
        logic [9:0] exp_r3;
    } vec_t;

    vec_t vecs [5];

    task automatic chk(input string name, input int act, input int exp);
        nchk++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    function automatic logic [W-1:0] pat(input int kind, input int r);
        if (r < 3 || r > 22) return 10'h2C3;
        case (kind)
            0: return 10'h155;
            1: return (r == 22) ? 10'h3FF : W'(r);
            2: return (r == 22 || r == 20 || r == 19) ? 10'h3FF : (r == 21) ? 10'h0AA : 10'h001;
            default: return 10'h3FF;
        endcase
    endfunction

    task automatic load(input int kind);
        for (int r = 0; r < 32; r++) begin
            @(negedge clk);
            bd_we   = 1'b1;
            bd_addr = 5'(r);
            bd_data = pat(kind, r);
        end
        @(negedge clk);
        bd_we = 1'b0;
    endtask

    task automatic snap();
        for (int r = 0; r < 32; r++) pre[r] = mem[r];
    endtask

    // Functional reference: keep non-full rows in order, packed to the bottom, zeros above.
    task automatic model(output int lines);
        int d;
        d = 22;
        lines = 0;
        for (int r = 0; r < 32; r++) exp_mem[r] = pre[r];
        for (int r = 22; r >= 3; r--) begin
            if (pre[r] == 10'h3FF) lines++;
            else begin
                exp_mem[d] = pre[r];
                d--;
            end
        end
        for (int r = d; r >= 3; r--) exp_mem[r] = '0;
    endtask

    function automatic bit stall_win(input int n);
        return (n <= 4) || (n >= 6 && n <= 10) || (n >= 16 && n <= 20) || (n >= 76 && n <= 80);
    endfunction

    // Called at a negedge with the DUT idle; returns at the negedge after the done cycle.
    task automatic run_pass(input bit stalls, input bit spam,
                            output int lat, output int writes, output int viol);
        lat    = -1;
        writes = 0;
        viol   = 0;
        start  = 1'b1;
        for (int n = 0; n < 200 && lat < 0; n++) begin
            @(negedge clk);
            start   = spam && (n == 10 || n == 30);
            bus_gnt = !(stalls && stall_win(n));
            #1;
            if ((rd_en || we) && !bus_gnt) viol++;
            if (!busy) viol++;
            if (bus_req != !done) viol++;
            if (we) writes++;
            if (done) begin
                lat = n + 1;
                if (spam) start = 1'b1;
            end
        end
        @(negedge clk);
        start   = 1'b0;
        bus_gnt = 1'b1;
        #1;
    endtask

    task automatic check_ram(input string name);
        int mism;
        mism = 0;
        for (int r = 0; r < 32; r++) if (mem[r] !== exp_mem[r]) mism++;
        chk(name, mism, 0);
    endtask

    initial begin
        int lat, wr, viol, mlines;

        vecs[0] = '{0, 1'b0, 63, 0, 0, 10'h155, 10'h155};
        vecs[1] = '{1, 1'b0, 64, 1, 20, 10'h015, 10'h000};
        vecs[2] = '{2, 1'b0, 66, 3, 20, 10'h0AA, 10'h000};
        vecs[3] = '{2, 1'b1, 86, 3, 20, 10'h0AA, 10'h000};
        vecs[4] = '{3, 1'b0, 83, 20, 20, 10'h000, 10'h000};

        #2;
        chk("reset_outs", int'({bus_req, rd_en, read_address, we, write_address,
                                bus_data_o, busy, done, lines_cleared}), 0);
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 5; i++) begin
            load(vecs[i].kind);
            snap();
            model(mlines);
            run_pass(vecs[i].stalls, 1'b0, lat, wr, viol);
            chk($sformatf("v%0d_latency", i), lat, vecs[i].exp_lat);
            chk($sformatf("v%0d_lines", i), int'(lines_cleared), vecs[i].exp_lines);
            chk($sformatf("v%0d_model_lines", i), int'(lines_cleared), mlines);
            chk($sformatf("v%0d_writes", i), wr, vecs[i].exp_writes);
            chk($sformatf("v%0d_protocol", i), viol, 0);
            chk($sformatf("v%0d_idle_after", i), int'({busy, done}), 0);
            chk($sformatf("v%0d_row22", i), int'(mem[22]), int'(vecs[i].exp_r22));
            chk($sformatf("v%0d_row3", i), int'(mem[3]), int'(vecs[i].exp_r3));
            check_ram($sformatf("v%0d_ram", i));
        end

        // Reset in the middle of FILL (all rows full: FILL writes span cycles 61..80).
        load(3);
        start = 1'b1;
        for (int n = 0; n < 70; n++) begin
            @(negedge clk);
            start = 1'b0;
        end
        #1;
        chk("midfill_we", int'(we), 1);
        #2;
        reset = 1'b0;
        #1;
        chk("midfill_reset_outs", int'({bus_req, rd_en, read_address, we, write_address,
                                        bus_data_o, busy, done, lines_cleared}), 0);
        @(negedge clk);
        reset = 1'b1;

        // Restart after reset with start pulses while busy and on the done cycle.
        load(1);
        snap();
        model(mlines);
        run_pass(1'b0, 1'b1, lat, wr, viol);
        chk("rs_latency", lat, 64);
        chk("rs_lines", int'(lines_cleared), 1);
        chk("rs_protocol", viol, 0);
        chk("rs_done_start_ignored", int'({busy, done}), 0);
        check_ram("rs_ram");

        // Start on the cycle right after done is accepted.
        snap();
        model(mlines);
        run_pass(1'b0, 1'b0, lat, wr, viol);
        chk("b2b_latency", lat, 63);
        chk("b2b_lines", int'(lines_cleared), 0);
        chk("b2b_writes", wr, 0);
        check_ram("b2b_ram");

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
